branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch predictor and resolver for the RV32I core; successor to the combinational branch-condition decoder. It is a direct-mapped branch target buffer with 2-bit saturating direction counters, read by fetch and updated by execute. Execute resolves the branch with the existing 3-bit branch code and ALU flags, flags mispredicts, supplies the redirect PC, and keeps branch and mispredict statistics.

## Interface
- XLEN, 32, address/data width
- IDX_W, 6, BTB index bits; 2**IDX_W entries
- TAG_W, 8, stored tag bits, taken from pc[IDX_W+2 +: TAG_W]
- CNT_W, 32, width of statistics counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- f_pc  in  XLEN  fetch PC for lookup
- f_pred_taken  out  1  prediction for f_pc
- f_pred_target  out  XLEN  predicted target; f_pc+4 when not taken
- ex_valid  in  1  execute slot holds a live instruction
- ex_branch  in  3  000 BEQ, 001 BNE, 010 BLT/BLTU, 011 BGE/BGEU, 100 JAL, 101 JALR, 110/111 no branch
- ex_less, ex_zero  in  1  ALU LessFlag / ZeroFlag
- ex_pc  in  XLEN  PC of execute instruction
- ex_target  in  XLEN  computed target (PC+imm, or rs1+imm with bit 0 cleared for JALR)
- ex_pred_taken, ex_pred_target  in  1 / XLEN  prediction carried down the pipe
- ex_mispredict  out  1  flush fetch/decode and redirect
- ex_redirect_pc  out  XLEN  correct next PC
- stat_branches, stat_mispredicts  out  CNT_W  resolved-branch and mispredict counts

## Operation
- Entry: valid, tag[TAG_W], target[XLEN], is_jump, ctr[2]. Index = pc[IDX_W+1:2].
- Lookup, combinational from state: hit = valid && tag match. f_pred_taken = hit && (is_jump || ctr[1]). f_pred_target = f_pred_taken ? target : f_pc+4.
- Resolve (ex_valid && ex_branch <= 101): taken is zero for BEQ, !zero for BNE, less for 010, !less for 011, 1 for JAL/JALR. Codes 110/111 are not branches: no update, no mispredict.
- ex_mispredict = resolve && (taken != ex_pred_taken || (taken && ex_target != ex_pred_target)). Combinational.
- ex_redirect_pc = taken ? ex_target : ex_pc+4. Driven as ex_pc+4 when not resolving.
- Update on a resolving cycle, written at the clock edge:
  - Hit: conditional branches step ctr (+1 when taken, saturating at 11; -1 when not taken, saturating at 00). Target is written when taken.
  - Miss and taken: allocate the entry with valid=1, the new tag, ex_target, is_jump=(code[2]), and ctr=10.
  - Miss and not taken: no allocation.
  - Jumps: ctr is left unchanged on a hit; it is don't-care.
- Stats: stat_branches increments on each resolve; stat_mispredicts increments on each mispredict. Both saturate at all-ones.

## Timing
- Lookup has zero latency. An update becomes visible to lookup on the cycle after the edge that writes it.
- When lookup and update hit the same index in the same cycle, lookup returns the pre-update value. There is no bypass.
- Resolve and mispredict are same-cycle combinational. Flush sequencing belongs to the pipeline, not to this block.
- Reset: all valid=0, all ctr=01, targets/tags=0, both stats=0. Outputs after reset: f_pred_taken=0, f_pred_target=f_pc+4, ex_mispredict=0 when ex_valid=0.
- Reset asserted during a resolve: the reset wins and no update occurs.
- Aliasing: a different PC with the same index but a different tag counts as a miss and replaces the entry only if taken.

## Structure
- bpu_pkg holds the branch code localparams (BR_BEQ … BR_NONE1), the counter state constants (SNT=00, WNT=01, WT=10, ST=11), and the entry struct or field widths.
- Sub-module branch_resolve is combinational: (ex_branch, ex_less, ex_zero) -> {is_branch, is_jump, taken}. It replaces the old decoder logic.
- Storage is a register array, small enough for a synchronous-reset loop.

## Test plan
- Reset, then lookup f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104. Stats are 0.
- BEQ at 0x100 with zero=1, target 0x180, pred 0 -> mispredict=1, redirect 0x180. The next cycle's lookup at 0x100 gives taken, 0x180, and ctr=10.
- Resolve the same branch as not taken twice, then taken once -> ctr goes 10→01→00→01. Lookup predicts not taken throughout after the first step.
- JAL at 0x200, target 0x400, correctly predicted -> no mispredict, stat_branches increments, stat_mispredicts unchanged.
- Same-index alias 0x100 vs 0x100+(4<<IDX_W): lookup of the alias misses. A taken resolve of the alias replaces the entry, and 0x100 then misses.
- Resolve and lookup on the same index in the same cycle -> lookup shows the old entry. rst asserted alongside a resolve -> entry stays invalid and stats are 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch codes, direction-counter states and
// the saturating counter step used by the predictor.
package bpu_pkg;

   localparam logic [2:0] BR_BEQ   = 3'b000;
   localparam logic [2:0] BR_BNE   = 3'b001;
   localparam logic [2:0] BR_LT    = 3'b010;
   localparam logic [2:0] BR_GE    = 3'b011;
   localparam logic [2:0] BR_JAL   = 3'b100;
   localparam logic [2:0] BR_JALR  = 3'b101;
   localparam logic [2:0] BR_NONE0 = 3'b110;
   localparam logic [2:0] BR_NONE1 = 3'b111;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   function automatic logic [1:0] ctr_step(
      input logic [1:0] c,
      input logic       up
   );
      if (up) return (c == ST) ? ST : c + 2'd1;
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Decodes the execute branch code and ALU flags
// into branch/jump class and the actual direction.
module branch_resolve
   import bpu_pkg::*;
(
   input  logic [2:0] ex_branch,
   input  logic       ex_less,
   input  logic       ex_zero,
   output logic       is_branch,
   output logic       is_jump,
   output logic       taken
);

   always_comb begin
      is_branch = 1'b1;
      is_jump   = 1'b0;
      taken     = 1'b0;
      unique case (ex_branch)
         BR_BEQ:  taken = ex_zero;
         BR_BNE:  taken = !ex_zero;
         BR_LT:   taken = ex_less;
         BR_GE:   taken = !ex_less;
         BR_JAL, BR_JALR: begin
            is_jump = 1'b1;
            taken   = 1'b1;
         end
         BR_NONE0, BR_NONE1: is_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters,
// execute-stage resolution and branch statistics.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6,
   parameter int TAG_W = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  f_pc,
   output logic             f_pred_taken,
   output logic [XLEN-1:0]  f_pred_target,
   input  logic             ex_valid,
   input  logic [2:0]       ex_branch,
   input  logic             ex_less,
   input  logic             ex_zero,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             ex_mispredict,
   output logic [XLEN-1:0]  ex_redirect_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int N = 1 << IDX_W;

   logic [N-1:0]      valid_q;
   logic [N-1:0]      jmp_q;
   logic [TAG_W-1:0]  tag_q [N];
   logic [XLEN-1:0]   tgt_q [N];
   logic [1:0]        ctr_q [N];
   logic [CNT_W-1:0]  br_q, br_d;
   logic [CNT_W-1:0]  mp_q, mp_d;

   logic [IDX_W-1:0]  f_idx, e_idx;
   logic [TAG_W-1:0]  f_tag, e_tag;
   logic              f_hit, e_hit;
   logic              is_branch, is_jump, taken, resolve;

   assign f_idx = f_pc[IDX_W+1:2];
   assign f_tag = f_pc[IDX_W+2 +: TAG_W];
   assign e_idx = ex_pc[IDX_W+1:2];
   assign e_tag = ex_pc[IDX_W+2 +: TAG_W];

   // Lookup reads only registered state: no bypass from execute.
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_pred_taken = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
   assign f_pred_target = f_pred_taken ? tgt_q[f_idx]
                                       : f_pc + XLEN'(4);

   branch_resolve u_resolve (
      .ex_branch (ex_branch),
      .ex_less   (ex_less),
      .ex_zero   (ex_zero),
      .is_branch (is_branch),
      .is_jump   (is_jump),
      .taken     (taken)
   );

   assign resolve = ex_valid && is_branch;
   assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

   assign ex_mispredict = resolve &&
      ((taken != ex_pred_taken) ||
       (taken && (ex_target != ex_pred_target)));
   assign ex_redirect_pc = (resolve && taken) ? ex_target
                                              : ex_pc + XLEN'(4);

   always_comb begin
      br_d = br_q;
      mp_d = mp_q;
      if (resolve && (br_q != '1)) br_d = br_q + CNT_W'(1);
      if (ex_mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         jmp_q   <= '0;
         br_q    <= '0;
         mp_q    <= '0;
         for (int i = 0; i < N; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
         end
      end else begin
         br_q <= br_d;
         mp_q <= mp_d;
         if (resolve) begin
            if (e_hit) begin
               if (!is_jump)
                  ctr_q[e_idx] <= ctr_step(ctr_q[e_idx], taken);
               if (taken) tgt_q[e_idx] <= ex_target;
            end else if (taken) begin
               valid_q[e_idx] <= 1'b1;
               tag_q[e_idx]   <= e_tag;
               tgt_q[e_idx]   <= ex_target;
               jmp_q[e_idx]   <= is_jump;
               ctr_q[e_idx]   <= WT;
            end
         end
      end
   end

   assign stat_branches    = br_q;
   assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and random checks of the predictor against
// a table-based reference model.
module tb_branch_predict_unit;

   localparam int XLEN  = 32;
   localparam int IDX_W = 6;
   localparam int TAG_W = 8;
   localparam int CNT_W = 4;
   localparam int N     = 1 << IDX_W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [XLEN-1:0]  f_pc;
   logic             f_pred_taken;
   logic [XLEN-1:0]  f_pred_target;
   logic             ex_valid;
   logic [2:0]       ex_branch;
   logic             ex_less, ex_zero;
   logic [XLEN-1:0]  ex_pc, ex_target;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             ex_mispredict;
   logic [XLEN-1:0]  ex_redirect_pc;
   logic [CNT_W-1:0] stat_branches, stat_mispredicts;

   branch_predict_unit #(
      .XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .f_pc             (f_pc),
      .f_pred_taken     (f_pred_taken),
      .f_pred_target    (f_pred_target),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_less          (ex_less),
      .ex_zero          (ex_zero),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .ex_mispredict    (ex_mispredict),
      .ex_redirect_pc   (ex_redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one slot per index, counters as plain ints 0..3.
   bit          m_v   [N];
   int unsigned m_tag [N];
   logic [31:0] m_tgt [N];
   bit          m_jmp [N];
   int          m_ctr [N];
   int          m_br, m_mp;

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int unsigned tag_of(logic [31:0] pc);
      return (pc >> (IDX_W + 2)) % (1 << TAG_W);
   endfunction

   function automatic bit taken_of(int code, bit less, bit zero);
      case (code)
         0: return zero;
         1: return !zero;
         2: return less;
         3: return !less;
         4, 5: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
         m_jmp[i] = 0; m_ctr[i] = 1;
      end
      m_br = 0; m_mp = 0;
   endtask

   task automatic model_pred(input logic [31:0] pc,
                             output bit t, output logic [31:0] tg);
      int i;
      bit hit;
      i = idx_of(pc);
      hit = m_v[i] && (m_tag[i] == tag_of(pc));
      t = hit && (m_jmp[i] || m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic chk(input string nm,
                      input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   // Check combinational outputs, clock once, update model, check stats.
   task automatic cycle(input string nm);
      bit pt, tk, res, mp, hit;
      logic [31:0] ptg, rd;
      int i;
      model_pred(f_pc, pt, ptg);
      tk  = taken_of(int'(ex_branch), ex_less, ex_zero);
      res = ex_valid && (ex_branch <= 3'd5);
      mp  = res && ((tk != ex_pred_taken) ||
                    (tk && ex_target != ex_pred_target));
      rd  = (res && tk) ? ex_target : ex_pc + 32'd4;
      #1;
      chk({nm, ".pred_taken"}, 32'(f_pred_taken), 32'(pt));
      chk({nm, ".pred_target"}, f_pred_target, ptg);
      chk({nm, ".mispredict"}, 32'(ex_mispredict), 32'(mp));
      chk({nm, ".redirect"}, ex_redirect_pc, rd);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (res) begin
         i = idx_of(ex_pc);
         hit = m_v[i] && (m_tag[i] == tag_of(ex_pc));
         if (hit) begin
            if (ex_branch < 3'd4)
               m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                             : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (tk) m_tgt[i] = ex_target;
         end else if (tk) begin
            m_v[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target;
            m_jmp[i] = ex_branch[2]; m_ctr[i] = 2;
         end
         if (m_br < CMAX) m_br++;
         if (mp && m_mp < CMAX) m_mp++;
      end
      @(negedge clk);
      chk({nm, ".stat_br"}, 32'(stat_branches), 32'(m_br));
      chk({nm, ".stat_mp"}, 32'(stat_mispredicts), 32'(m_mp));
   endtask

   task automatic resolve_in(input logic [2:0] code, input bit z,
                             input bit l, input logic [31:0] pc,
                             input logic [31:0] tgt, input bit pt,
                             input logic [31:0] ptg);
      ex_valid = 1'b1; ex_branch = code; ex_zero = z; ex_less = l;
      ex_pc = pc; ex_target = tgt;
      ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_branch = 3'b110; ex_zero = 1'b0;
      ex_less = 1'b0; ex_pc = 32'h0; ex_target = 32'h0;
      ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
   endtask

   task automatic look(input string nm, input logic [31:0] pc,
                       input bit et, input logic [31:0] etg);
      f_pc = pc;
      #1;
      chk({nm, ".taken"}, 32'(f_pred_taken), 32'(et));
      chk({nm, ".target"}, f_pred_target, etg);
   endtask

   initial begin
      logic [CNT_W-1:0] mp_before;
      bit pt;
      logic [31:0] ptg;
      model_reset();
      rst = 1'b1; f_pc = 32'h100; idle_ex();
      @(negedge clk);
      cycle("reset");
      rst = 1'b0;
      look("after_reset", 32'h100, 1'b0, 32'h104);
      chk("reset.stat_br", 32'(stat_branches), 32'h0);
      chk("reset.stat_mp", 32'(stat_mispredicts), 32'h0);
      cycle("idle");

      // BEQ first seen, taken, predicted not taken
      resolve_in(3'b000, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 32'h104);
      #1;
      chk("beq.mispredict", 32'(ex_mispredict), 32'h1);
      chk("beq.redirect", ex_redirect_pc, 32'h180);
      cycle("beq_alloc");
      idle_ex();
      look("beq_lookup", 32'h100, 1'b1, 32'h180);

      // not taken, not taken, taken: 10 -> 01 -> 00 -> 01
      resolve_in(3'b000, 1'b0, 1'b0, 32'h100, 32'h180, 1'b1, 32'h180);
      cycle("beq_nt1");
      look("beq_nt1_lookup", 32'h100, 1'b0, 32'h104);
      resolve_in(3'b000, 1'b0, 1'b0, 32'h100, 32'h180, 1'b0, 32'h104);
      cycle("beq_nt2");
      look("beq_nt2_lookup", 32'h100, 1'b0, 32'h104);
      resolve_in(3'b000, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 32'h104);
      cycle("beq_t3");
      look("beq_t3_lookup", 32'h100, 1'b0, 32'h104);

      // JAL at an aliasing PC, correctly predicted
      mp_before = stat_mispredicts;
      resolve_in(3'b100, 1'b0, 1'b0, 32'h200, 32'h400, 1'b1, 32'h400);
      look("alias_miss", 32'h200, 1'b0, 32'h204);
      chk("jal.no_mispredict", 32'(ex_mispredict), 32'h0);
      cycle("jal");
      chk("jal.stat_mp_same", 32'(stat_mispredicts), 32'(mp_before));
      idle_ex();
      look("alias_new_hit", 32'h200, 1'b1, 32'h400);
      look("alias_old_miss", 32'h100, 1'b0, 32'h104);
      cycle("alias_idle");

      // Same-index resolve and lookup: lookup sees the old entry
      resolve_in(3'b001, 1'b0, 1'b0, 32'h104, 32'h500, 1'b0, 32'h108);
      look("same_cycle_old", 32'h104, 1'b0, 32'h108);
      cycle("same_cycle");
      idle_ex();
      look("same_cycle_new", 32'h104, 1'b1, 32'h500);

      // Reset alongside a resolve: reset wins
      rst = 1'b1;
      resolve_in(3'b100, 1'b0, 1'b0, 32'h300, 32'h700, 1'b0, 32'h304);
      cycle("rst_resolve");
      rst = 1'b0; idle_ex();
      look("rst_resolve_lookup", 32'h300, 1'b0, 32'h304);
      chk("rst_resolve.stat_br", 32'(stat_branches), 32'h0);
      cycle("post_rst");

      // Random traffic over a small aliasing PC set
      for (int k = 0; k < 600; k++) begin
         logic [31:0] p;
         p = 32'h1000 + (32'($urandom_range(0, 7)) << 2)
                      + (32'($urandom_range(0, 1)) << (IDX_W + 2));
         ex_valid  = ($urandom_range(0, 9) != 0);
         ex_branch = 3'($urandom_range(0, 7));
         ex_less   = 1'($urandom);
         ex_zero   = 1'($urandom);
         ex_pc     = p;
         ex_target = 32'h2000 + (32'($urandom_range(0, 3)) << 6);
         if ($urandom_range(0, 1) == 0) begin
            model_pred(p, pt, ptg);
            ex_pred_taken = pt; ex_pred_target = ptg;
         end else begin
            ex_pred_taken  = 1'($urandom);
            ex_pred_target = 32'h2000 + (32'($urandom_range(0, 3)) << 6);
         end
         f_pc = 32'h1000 + (32'($urandom_range(0, 7)) << 2)
                         + (32'($urandom_range(0, 1)) << (IDX_W + 2));
         rst = ($urandom_range(0, 199) == 0);
         cycle("rand");
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
